// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider.
// Accepts one operand pair at a time, iterates one quotient bit per clock and
// holds the result until the consumer takes it. SIGNED selects unsigned or
// two's-complement operation (quotient truncates toward zero, remainder takes
// the dividend's sign). A zero divisor bypasses the iteration and returns an
// all-ones quotient with the dividend as remainder.
module seq_divider #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk_100mhz,
   input  logic             sys_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WIDTH-1:0]   quo_r;        // dividend shifts out, quotient bits shift in
   logic [WIDTH-1:0]   dvs_r;        // divisor magnitude
   logic [WIDTH:0]     rem_r;        // partial remainder, one guard bit
   logic [CW-1:0]      cnt_r;        // iterations still to run
   logic               neg_q_r;
   logic               neg_r_r;

   logic               accept_s;
   logic               div_zero_s;
   logic               last_iter_s;
   logic [WIDTH+1:0]   shift_s;
   logic [WIDTH+1:0]   diff_s;
   logic               take_s;
   logic [WIDTH:0]     rem_nxt_s;
   logic [WIDTH-1:0]   quo_nxt_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   // Two's-complement negation of a result-width value.
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return (~v) + ONE_W;
   endfunction

   // Operand magnitude; the most-negative value maps to 2^(WIDTH-1), which
   // still fits as an unsigned WIDTH-bit number.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] m;
      if (SIGNED && v[WIDTH-1]) begin
         m = negate(v);
      end else begin
         m = v;
      end
      return m;
   endfunction

   assign in_ready    = (state_r == IDLE);
   assign busy        = (state_r != IDLE);
   assign accept_s    = in_valid && (state_r == IDLE);
   assign div_zero_s  = (divisor == ZERO_W);
   assign last_iter_s = (cnt_r == CNT_ONE);

   // One restoring step plus sign correction of the step's outcome.
   always_comb begin
      shift_s   = {rem_r, quo_r[WIDTH-1]};
      diff_s    = shift_s - {2'b00, dvs_r};
      take_s    = ~diff_s[WIDTH+1];
      rem_nxt_s = shift_s[WIDTH:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], take_s};
      if (take_s) begin
         rem_nxt_s = diff_s[WIDTH:0];
      end else begin
         rem_nxt_s = shift_s[WIDTH:0];
      end
      if (neg_q_r) begin
         quo_fix_s = negate(quo_nxt_s);
      end else begin
         quo_fix_s = quo_nxt_s;
      end
      if (neg_r_r) begin
         rem_fix_s = negate(rem_nxt_s[WIDTH-1:0]);
      end else begin
         rem_fix_s = rem_nxt_s[WIDTH-1:0];
      end
   end

   // Next-state decode for the IDLE/CALC/DONE controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (div_zero_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = CALC;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (last_iter_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand capture, iteration datapath and registered result outputs.
   always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         quo_r       <= ZERO_W;
         dvs_r       <= ZERO_W;
         rem_r       <= {(WIDTH+1){1'b0}};
         cnt_r       <= {CW{1'b0}};
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         quotient    <= ZERO_W;
         remainder   <= ZERO_W;
         div_by_zero <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  if (div_zero_s) begin
                     quotient    <= {WIDTH{1'b1}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     out_valid   <= 1'b1;
                  end else begin
                     quo_r   <= magnitude(dividend);
                     dvs_r   <= magnitude(divisor);
                     rem_r   <= {(WIDTH+1){1'b0}};
                     cnt_r   <= CNT_INIT;
                     neg_q_r <= SIGNED & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r_r <= SIGNED & dividend[WIDTH-1];
                  end
               end
            end
            CALC: begin
               quo_r <= quo_nxt_s;
               rem_r <= rem_nxt_s;
               cnt_r <= cnt_r - CNT_ONE;
               if (last_iter_s) begin
                  quotient    <= quo_fix_s;
                  remainder   <= rem_fix_s;
                  div_by_zero <= 1'b0;
                  out_valid   <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               out_valid   <= 1'b0;
               div_by_zero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: one unsigned and one signed
// 32-bit instance sharing clock and reset, with hand-computed expectations.
module tb_seq_divider;

   logic        clk;
   logic        rst_n;
   logic        iv   [2];
   logic        ir   [2];
   logic [31:0] dvd  [2];
   logic [31:0] dvs  [2];
   logic        ov   [2];
   logic        ordy [2];
   logic [31:0] q    [2];
   logic [31:0] r    [2];
   logic        dz   [2];
   logic        bsy  [2];

   int tests = 0;
   int fails = 0;

   seq_divider #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
      .clk_100mhz (clk),     .sys_rst_n (rst_n),
      .in_valid   (iv[0]),   .in_ready  (ir[0]),
      .dividend   (dvd[0]),  .divisor   (dvs[0]),
      .out_valid  (ov[0]),   .out_ready (ordy[0]),
      .quotient   (q[0]),    .remainder (r[0]),
      .div_by_zero(dz[0]),   .busy      (bsy[0])
   );

   seq_divider #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (
      .clk_100mhz (clk),     .sys_rst_n (rst_n),
      .in_valid   (iv[1]),   .in_ready  (ir[1]),
      .dividend   (dvd[1]),  .divisor   (dvs[1]),
      .out_valid  (ov[1]),   .out_ready (ordy[1]),
      .quotient   (q[1]),    .remainder (r[1]),
      .div_by_zero(dz[1]),   .busy      (bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction with out_ready held high; garbage operands and a
   // stray in_valid are applied while the divider iterates.
   task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat, input string tag);
      int lat;
      @(negedge clk);
      dvd[s]  = a;
      dvs[s]  = b;
      iv[s]   = 1'b1;
      ordy[s] = 1'b1;
      chk({tag, "/in_ready"}, {31'd0, ir[s]}, 32'd1);
      @(posedge clk); #1;
      lat    = 1;
      dvd[s] = ~a;
      dvs[s] = b + 32'd5;
      if (elat > 4) begin
         chk({tag, "/busy"}, {31'd0, bsy[s]}, 32'd1);
         repeat (3) begin
            @(posedge clk); #1;
            lat++;
         end
      end else begin
         lat = 1;
      end
      iv[s] = 1'b0;
      while (ov[s] !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 32'(lat), 32'(elat));
      chk({tag, "/quotient"}, q[s], eq);
      chk({tag, "/remainder"}, r[s], er);
      chk({tag, "/div_by_zero"}, {31'd0, dz[s]}, {31'd0, edz});
      @(posedge clk); #1;
      chk({tag, "/out_valid_clr"}, {31'd0, ov[s]}, 32'd0);
      chk({tag, "/dz_clr"}, {31'd0, dz[s]}, 32'd0);
      chk({tag, "/in_ready_back"}, {31'd0, ir[s]}, 32'd1);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b1; dvd[i] = 32'd0; dvs[i] = 32'd0;
      end
      #1;
      chk("rst/out_valid", {31'd0, ov[0]}, 32'd0);
      chk("rst/quotient", q[0], 32'd0);
      chk("rst/remainder", r[1], 32'd0);
      chk("rst/busy", {31'd0, bsy[1]}, 32'd0);
      chk("rst/in_ready", {31'd0, ir[0]}, 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Unsigned
      run_op(0, 32'd100,        32'd7,        32'd14,         32'd2,        1'b0, 33, "u_100_7");
      run_op(0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF,  32'h0000_1234, 1'b1, 1, "u_div0");
      run_op(0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,        1'b0, 33, "u_max_1");
      run_op(0, 32'd5,          32'd9,        32'd0,          32'd5,        1'b0, 33, "u_5_9");
      run_op(0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'd0,        1'b0, 33, "u_max_max");
      run_op(0, 32'h8000_0000,  32'd3,        32'h2AAA_AAAA,  32'd2,        1'b0, 33, "u_msb_3");

      // Signed
      run_op(1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 33, "s_m7_2");
      run_op(1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 33, "s_7_m2");
      run_op(1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33, "s_min_m1");
      run_op(1, 32'hFFFF_FFF7,  32'hFFFF_FFFC, 32'd2,         32'hFFFF_FFFF, 1'b0, 33, "s_m9_m4");
      run_op(1, 32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFF0, 1'b1, 1, "s_div0");

      // Back-pressure: hold result for 10 cycles
      @(negedge clk);
      dvd[0] = 32'd100; dvs[0] = 32'd7; iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      lat = 1;
      while (ov[0] !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold/latency", 32'(lat), 32'd33);
      repeat (10) begin
         @(posedge clk); #1;
         chk("hold/quotient", q[0], 32'd14);
         chk("hold/remainder", r[0], 32'd2);
         chk("hold/out_valid", {31'd0, ov[0]}, 32'd1);
         chk("hold/in_ready", {31'd0, ir[0]}, 32'd0);
      end
      @(negedge clk);
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("hold/release_ov", {31'd0, ov[0]}, 32'd0);
      chk("hold/release_busy", {31'd0, bsy[0]}, 32'd0);
      chk("hold/release_ir", {31'd0, ir[0]}, 32'd1);
      run_op(0, 32'd1000000,    32'd1000,     32'd1000,       32'd0,        1'b0, 33, "u_b2b");

      // Reset in the middle of CALC
      @(negedge clk);
      dvd[0] = 32'd1000; dvs[0] = 32'd7; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("midrst/busy_before", {31'd0, bsy[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst/out_valid", {31'd0, ov[0]}, 32'd0);
      chk("midrst/busy", {31'd0, bsy[0]}, 32'd0);
      chk("midrst/quotient", q[0], 32'd0);
      chk("midrst/in_ready", {31'd0, ir[0]}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst/in_ready_rel", {31'd0, ir[0]}, 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("midrst/no_stale_ov", {31'd0, ov[0]}, 32'd0);
      end
      run_op(0, 32'd9,          32'd3,        32'd3,          32'd0,        1'b0, 33, "u_9_3");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
